// File: rtl/timer_core.sv
// HH:MM:SS BCD timer engine: count up/down, BCD preload, lap hold, done pulse and blink LED.
// Digit order in packed vectors is {hr1, hr0, min1, min0, sec1, sec0}.
module timer_core #(
   parameter int TICK_DIV = 100_000_000,
   parameter int HR_MAX   = 23,
   parameter bit WRAP     = 1'b1
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       run_tgl,
   input  logic       clr,
   input  logic       mode,
   input  logic       load,
   input  logic [7:0] ld_sec,
   input  logic [7:0] ld_min,
   input  logic [7:0] ld_hr,
   input  logic       lap,
   output logic [3:0] sec0,
   output logic [3:0] sec1,
   output logic [3:0] min0,
   output logic [3:0] min1,
   output logic [3:0] hr0,
   output logic [3:0] hr1,
   output logic       running,
   output logic       hold,
   output logic       done,
   output logic       load_err,
   output logic       led
);

   localparam int             PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0]  PRE_HALF = PW'(TICK_DIV / 2);
   localparam logic [23:0]    CNT_MAX  = {4'(HR_MAX / 10), 4'(HR_MAX % 10), 16'h5959};

   logic [23:0]   r_cnt;
   logic [23:0]   r_snap;
   logic [PW-1:0] r_pre;
   logic          r_run;
   logic          r_hold;
   logic          r_done;
   logic          r_lerr;

   logic [23:0]   w_cnt_nx;
   logic [PW-1:0] w_pre_nx;
   logic          w_run_nx;
   logic          w_done_nx;
   logic          w_lerr_nx;
   logic [7:0]    w_ld_hr_val;
   logic          w_ld_ok;

   // Seconds/minutes tens roll over at 5; hour units at 9; hour tens just increments.
   function automatic logic [23:0] bcd_up(input logic [23:0] c);
      logic [5:0][3:0] d;
      logic            cy;
      logic [3:0]      lim;
      d  = c;
      cy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lim = (i == 1 || i == 3) ? 4'd5 : 4'd9;
         if (cy) begin
            if (i == 5) begin
               d[i] = d[i] + 4'd1;
               cy   = 1'b0;
            end else if (d[i] == lim) begin
               d[i] = 4'd0;
            end else begin
               d[i] = d[i] + 4'd1;
               cy   = 1'b0;
            end
         end
      end
      return d;
   endfunction

   function automatic logic [23:0] bcd_dn(input logic [23:0] c);
      logic [5:0][3:0] d;
      logic            bw;
      logic [3:0]      lim;
      d  = c;
      bw = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lim = (i == 1 || i == 3) ? 4'd5 : 4'd9;
         if (bw) begin
            if (i == 5) begin
               d[i] = d[i] - 4'd1;
               bw   = 1'b0;
            end else if (d[i] == 4'd0) begin
               d[i] = lim;
            end else begin
               d[i] = d[i] - 4'd1;
               bw   = 1'b0;
            end
         end
      end
      return d;
   endfunction

   assign w_ld_hr_val = {4'd0, ld_hr[7:4]} * 8'd10 + {4'd0, ld_hr[3:0]};
   assign w_ld_ok = (ld_sec[3:0] <= 4'd9) && (ld_sec[7:4] <= 4'd5) &&
                    (ld_min[3:0] <= 4'd9) && (ld_min[7:4] <= 4'd5) &&
                    (ld_hr[3:0]  <= 4'd9) && (ld_hr[7:4]  <= 4'd9) &&
                    (w_ld_hr_val <= 8'(HR_MAX));

   // Priority clr > load > run_tgl > tick; only the winner acts this cycle.
   always_comb begin
      w_cnt_nx  = r_cnt;
      w_pre_nx  = r_pre;
      w_run_nx  = r_run;
      w_done_nx = 1'b0;
      w_lerr_nx = 1'b0;
      if (clr) begin
         w_cnt_nx = '0;
         w_pre_nx = '0;
         w_run_nx = 1'b0;
      end else if (load) begin
         if (r_run || !w_ld_ok) begin
            w_lerr_nx = 1'b1;
         end else begin
            w_cnt_nx = {ld_hr, ld_min, ld_sec};
            w_pre_nx = '0;
         end
      end else if (run_tgl) begin
         if (r_run || !mode || (r_cnt != 24'h0))
            w_run_nx = !r_run;
      end else if (r_run) begin
         if (r_pre == PRE_LAST) begin
            w_pre_nx = '0;
            if (!mode) begin
               if (r_cnt == CNT_MAX) begin
                  w_done_nx = 1'b1;
                  if (WRAP) w_cnt_nx = '0;
                  else      w_run_nx = 1'b0;
               end else begin
                  w_cnt_nx = bcd_up(r_cnt);
               end
            end else if (r_cnt == 24'h0 || r_cnt == 24'h1) begin
               w_cnt_nx  = '0;
               w_done_nx = 1'b1;
               w_run_nx  = 1'b0;
            end else begin
               w_cnt_nx = bcd_dn(r_cnt);
            end
         end else begin
            w_pre_nx = r_pre + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt  <= '0;
         r_pre  <= '0;
         r_run  <= 1'b0;
         r_done <= 1'b0;
         r_lerr <= 1'b0;
         r_hold <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nx;
         r_pre  <= w_pre_nx;
         r_run  <= w_run_nx;
         r_done <= w_done_nx;
         r_lerr <= w_lerr_nx;
         if (clr)       r_hold <= 1'b0;
         else if (lap)  r_hold <= !r_hold;
      end
   end

   // Snapshot is only visible while r_hold is set, so it needs no reset.
   always_ff @(posedge clk) begin
      if (!clr && lap && !r_hold)
         r_snap <= r_cnt;
   end

   assign {hr1, hr0, min1, min0, sec1, sec0} = r_hold ? r_snap : r_cnt;
   assign running  = r_run;
   assign hold     = r_hold;
   assign done     = r_done;
   assign load_err = r_lerr;
   assign led      = r_run && (r_pre < PRE_HALF);

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: two instances (WRAP=0 and WRAP=1) driven in parallel against a seconds-based model.
module tb_timer_core;

   localparam int TD   = 4;
   localparam int HRM  = 1;
   localparam int MAXT = HRM * 3600 + 3599;

   logic       clk = 1'b0, rstn = 1'b0;
   logic       run_tgl = 1'b0, clr = 1'b0, mode = 1'b0, load = 1'b0, lap = 1'b0;
   logic [7:0] ld_sec = 8'h0, ld_min = 8'h0, ld_hr = 8'h0;

   logic [3:0] o_s0 [2], o_s1 [2], o_m0 [2], o_m1 [2], o_h0 [2], o_h1 [2];
   logic       o_run [2], o_hold [2], o_done [2], o_lerr [2], o_led [2];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   timer_core #(.TICK_DIV(TD), .HR_MAX(HRM), .WRAP(1'b0)) dut0 (
      .clk(clk), .rstn(rstn), .run_tgl(run_tgl), .clr(clr), .mode(mode), .load(load),
      .ld_sec(ld_sec), .ld_min(ld_min), .ld_hr(ld_hr), .lap(lap),
      .sec0(o_s0[0]), .sec1(o_s1[0]), .min0(o_m0[0]), .min1(o_m1[0]), .hr0(o_h0[0]), .hr1(o_h1[0]),
      .running(o_run[0]), .hold(o_hold[0]), .done(o_done[0]), .load_err(o_lerr[0]), .led(o_led[0]));

   timer_core #(.TICK_DIV(TD), .HR_MAX(HRM), .WRAP(1'b1)) dut1 (
      .clk(clk), .rstn(rstn), .run_tgl(run_tgl), .clr(clr), .mode(mode), .load(load),
      .ld_sec(ld_sec), .ld_min(ld_min), .ld_hr(ld_hr), .lap(lap),
      .sec0(o_s0[1]), .sec1(o_s1[1]), .min0(o_m0[1]), .min1(o_m1[1]), .hr0(o_h0[1]), .hr1(o_h1[1]),
      .running(o_run[1]), .hold(o_hold[1]), .done(o_done[1]), .load_err(o_lerr[1]), .led(o_led[1]));

   // Model: count kept as total seconds; index k matches dut k (k==1 wraps).
   int m_t [2], m_pre [2], m_snap [2];
   bit m_run [2], m_hold [2], m_done [2], m_lerr [2];

   function automatic logic [23:0] to_bcd(input int t);
      int h, m, s;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic [23:0] dig(input int k);
      return {o_h1[k], o_h0[k], o_m1[k], o_m0[k], o_s1[k], o_s0[k]};
   endfunction

   always @(posedge clk or negedge rstn) begin
      for (int k = 0; k < 2; k++) begin
         if (!rstn) begin
            m_t[k] = 0; m_pre[k] = 0; m_run[k] = 0; m_hold[k] = 0;
            m_done[k] = 0; m_lerr[k] = 0; m_snap[k] = 0;
         end else begin
            int su, st, mu, mt, hu, ht;
            bit ok;
            m_done[k] = 0;
            m_lerr[k] = 0;
            if (clr) m_hold[k] = 0;
            else if (lap) begin
               if (!m_hold[k]) begin m_snap[k] = m_t[k]; m_hold[k] = 1; end
               else m_hold[k] = 0;
            end
            su = int'(ld_sec[3:0]); st = int'(ld_sec[7:4]);
            mu = int'(ld_min[3:0]); mt = int'(ld_min[7:4]);
            hu = int'(ld_hr[3:0]);  ht = int'(ld_hr[7:4]);
            ok = su < 10 && mu < 10 && hu < 10 && st < 6 && mt < 6 && ht < 10 && (ht * 10 + hu) <= HRM;
            if (clr) begin
               m_t[k] = 0; m_pre[k] = 0; m_run[k] = 0;
            end else if (load) begin
               if (m_run[k] || !ok) m_lerr[k] = 1;
               else begin
                  m_t[k]   = (ht * 10 + hu) * 3600 + (mt * 10 + mu) * 60 + st * 10 + su;
                  m_pre[k] = 0;
               end
            end else if (run_tgl) begin
               if (!(!m_run[k] && mode && m_t[k] == 0)) m_run[k] = !m_run[k];
            end else if (m_run[k]) begin
               if (m_pre[k] == TD - 1) begin
                  m_pre[k] = 0;
                  if (!mode) begin
                     if (m_t[k] == MAXT) begin
                        m_done[k] = 1;
                        if (k == 1) m_t[k] = 0;
                        else        m_run[k] = 0;
                     end else m_t[k] = m_t[k] + 1;
                  end else if (m_t[k] <= 1) begin
                     m_t[k] = 0; m_done[k] = 1; m_run[k] = 0;
                  end else m_t[k] = m_t[k] - 1;
               end else m_pre[k] = m_pre[k] + 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         for (int k = 0; k < 2; k++) begin
            logic [31:0] a, e;
            int shown;
            shown = m_hold[k] ? m_snap[k] : m_t[k];
            e = {3'b0, to_bcd(shown), m_run[k], m_hold[k], m_done[k], m_lerr[k],
                 1'(m_run[k] && m_pre[k] < TD / 2)};
            a = {3'b0, dig(k), o_run[k], o_hold[k], o_done[k], o_lerr[k], o_led[k]};
            chk($sformatf("cycle_dut%0d", k), a, e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      run_tgl = 0; clr = 0; load = 0; lap = 0;
   endtask

   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      ld_hr = h; ld_min = m; ld_sec = s; load = 1;
      step();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_digits", 32'(dig(0)), 32'h0);
      chk("rst_run_led", {o_run[0], o_led[0], o_hold[0], o_done[0], o_lerr[0]}, 32'h0);
      rstn = 1;

      // Up count 40 cycles with TICK_DIV=4 -> 10 seconds, led alternating
      mode = 0; run_tgl = 1; step();
      repeat (40) step();
      chk("up40_digits", 32'(dig(0)), 32'h000010);
      chk("up40_led_hi", 32'(o_led[0]), 32'h1);
      repeat (2) step();
      chk("up42_led_lo", 32'(o_led[0]), 32'h0);
      clr = 1; step();

      // Terminal at 01:59:59: dut0 saturates, dut1 wraps
      do_load(8'h01, 8'h59, 8'h58);
      run_tgl = 1; step();
      repeat (8) step();
      chk("sat_digits", 32'(dig(0)), 32'h015959);
      chk("sat_run_done", {o_run[0], o_done[0]}, 32'h1);
      chk("wrap_digits", 32'(dig(1)), 32'h0);
      chk("wrap_run_done", {o_run[1], o_done[1]}, 32'h3);
      step();
      chk("sat_done_pulse", 32'(o_done[0]), 32'h0);
      clr = 1; step();

      // Down count with borrow chain to zero
      mode = 1;
      do_load(8'h00, 8'h01, 8'h00);
      run_tgl = 1; step();
      repeat (4) step();
      chk("down_borrow", 32'(dig(0)), 32'h000059);
      repeat (236) step();
      chk("down_zero", 32'(dig(0)), 32'h0);
      chk("down_done_stop", {o_run[0], o_done[0]}, 32'h1);
      run_tgl = 1; step();
      chk("down_zero_tgl", 32'(o_run[0]), 32'h0);

      // Load rejections
      mode = 0;
      do_load(8'h00, 8'h00, 8'h60);
      chk("ld_bad_sec_err", 32'(o_lerr[0]), 32'h1);
      chk("ld_bad_sec_dig", 32'(dig(0)), 32'h0);
      do_load(8'h02, 8'h00, 8'h00);
      chk("ld_bad_hr_err", 32'(o_lerr[0]), 32'h1);
      do_load(8'h00, 8'h00, 8'h03);
      chk("ld_ok", {o_lerr[0], dig(0)}, 32'h000003);
      run_tgl = 1; step();
      do_load(8'h00, 8'h00, 8'h01);
      chk("ld_running_err", {o_lerr[0], dig(0)}, 32'h1000003);

      // Lap hold
      clr = 1; step();
      run_tgl = 1; step();
      repeat (20) step();
      chk("lap_pre", 32'(dig(0)), 32'h000005);
      lap = 1; step();
      repeat (12) step();
      chk("lap_hold", {o_hold[0], dig(0)}, 32'h1000005);
      lap = 1; step();
      chk("lap_release", {o_hold[0], dig(0)}, 32'h0000008);

      // clr beats load, run_tgl and lap
      clr = 1; step();
      run_tgl = 1; step();
      repeat (28) step();
      chk("prio_pre", 32'(dig(0)), 32'h000007);
      ld_hr = 8'h00; ld_min = 8'h00; ld_sec = 8'h30;
      clr = 1; load = 1; run_tgl = 1; lap = 1; step();
      chk("prio_clr", {o_run[0], o_hold[0], o_lerr[0], dig(0)}, 32'h0);

      // Asynchronous reset mid-count
      run_tgl = 1; step();
      repeat (10) step();
      #1 rstn = 0;
      #1 chk("async_rst", {o_run[0], dig(0)}, 32'h0);
      #2 rstn = 1;

      // Randomized traffic
      mode = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3000; i++) begin
         int r;
         run_tgl = ($urandom % 12) == 0;
         clr     = ($urandom % 200) == 0;
         lap     = ($urandom % 40) == 0;
         load    = ($urandom % 25) == 0;
         if (($urandom % 100) == 0) mode = ~mode;
         if (load) begin
            r = int'($urandom % 4);
            case (r)
               0: begin ld_hr = 8'($urandom); ld_min = 8'($urandom); ld_sec = 8'($urandom); end
               1: begin ld_hr = 8'h01; ld_min = 8'h59; ld_sec = {4'h5, 4'($urandom_range(0, 9))}; end
               2: begin ld_hr = 8'h00; ld_min = 8'h00; ld_sec = {4'h0, 4'($urandom_range(0, 9))}; end
               default: begin
                  ld_hr  = {4'h0, 4'($urandom_range(0, 1))};
                  ld_min = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                  ld_sec = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
               end
            endcase
         end
         step();
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/timer_core.md
# timer_core

Parametrised HH:MM:SS timer engine: the successor to the fixed count-up stopwatch logic. Adds count-up and count-down modes, BCD preload, lap hold of the displayed value, configurable hour range and terminal behaviour, and a done flag. It sits between the button front end and the hex-to-seven-segment and display-mux stage. It drives six BCD digits plus a seconds blink LED.

## Interface
- TICK_DIV, 100_000_000: clk cycles per counted second (≥ 2)
- HR_MAX, 23: highest hour value, 1..99
- WRAP, 1: count-up at HR_MAX:59:59 wraps to 00:00:00 (1) or saturates and stops (0)

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- run_tgl  in  1  one-cycle pulse; toggles run/pause
- clr  in  1  one-cycle pulse; zero the count, stop, release lap hold
- mode  in  1  0 = count up, 1 = count down
- load  in  1  one-cycle pulse; preload from ld_* (ignored while running)
- ld_sec, ld_min, ld_hr  in  8 each  BCD preload value, {tens, units}
- lap  in  1  one-cycle pulse; toggles lap hold
- sec0, sec1, min0, min1, hr0, hr1  out  4 each  displayed BCD digits
- running  out  1  timer is counting
- hold  out  1  lap hold active
- done  out  1  one-cycle pulse on terminal event
- load_err  out  1  one-cycle pulse; load rejected
- led  out  1  seconds blink

## Operation
- State: live count (six BCD digits), prescaler pre[$clog2(TICK_DIV)-1:0], run flag, hold flag, snapshot register (six digits).
- Reset: all digits 0, pre = 0, running = 0, hold = 0, done = 0, load_err = 0, led = 0.
- Per-cycle priority: clr > load > run_tgl > tick.
  - Simultaneous pulses: only the highest-priority one is acted on.
  - lap is independent of this chain, except that clr wins over lap.
- Prescaler: advances only while running. On pre == TICK_DIV-1 it returns to 0 and fires a tick.
  - Pause holds pre.
  - clr zeroes pre; a valid load zeroes pre.
- Count up on tick:
  - sec0 9→0 carries into sec1; sec1 5→0 carries into min0; minutes follow the same pattern; minute carry increments the hour.
  - At HR_MAX:59:59 with WRAP=1: wrap to 00:00:00 and pulse done; keep running.
  - At HR_MAX:59:59 with WRAP=0: hold the value, pulse done, clear running.
- Count down on tick:
  - Borrow is mirror-image: sec0 0→9 borrows from sec1, sec1 0→5 borrows from minutes, minutes borrow from the hour.
  - The tick that produces 00:00:00 pulses done and clears running.
- run_tgl:
  - While stopped in down mode at 00:00:00 it is ignored (running stays 0).
  - All other run_tgl pulses toggle running.
- mode: sampled on every tick. Changing it mid-run changes direction from the next tick onward.
- load:
  - Rejected with a load_err pulse if running, if any units nibble > 9, if any seconds/minutes tens nibble > 5, or if ld_hr > HR_MAX or ld_hr tens > 9.
  - A rejected load leaves the state unchanged.
  - A valid load copies ld_* into the count; running stays 0.
- lap:
  - From hold = 0: the snapshot captures the live count and hold becomes 1.
  - From hold = 1: hold becomes 0.
  - The count continues regardless of hold.
- Outputs: digit outputs show the snapshot while hold = 1, otherwise the live count.
- led = running && (pre < TICK_DIV/2); 0 while paused.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- A tick detected at pre == TICK_DIV-1 updates the count at that same edge. The new digits are visible the following cycle, so first increment after run start lands TICK_DIV cycles after the run_tgl edge.
- done, load_err: exactly one cycle high, asserted at the edge that performs the terminal update or the rejection.
- running falls at the same edge as done for terminal stops.
- clr/load/run_tgl/lap take effect at the sampling edge; outputs reflect them the next cycle.
- The lap snapshot takes the live count as of the lap edge, before any tick applied at that same edge.
- rstn asserted mid-count clears everything asynchronously. The first tick after release needs a full TICK_DIV cycles of running.

## Test plan
- TICK_DIV=4, up mode: reset, run_tgl, 40 cycles → digits 00:00:10, led toggling every 2 cycles, done never set.
- Load 01:59:58, up mode, HR_MAX=1, WRAP=0, run 8 cycles → digits hold 01:59:59, done one pulse, running=0.
- Down mode: load 00:01:00, run 4 cycles → 00:00:59 (borrow chain). Continue 236 more cycles → 00:00:00, done pulse, running=0; a further run_tgl leaves running=0.
- load ld_sec=8'h60 → load_err pulse, digits unchanged. load while running → load_err.
- lap at 00:00:05, run 12 more cycles → outputs still 00:00:05, hold=1. Second lap → outputs 00:00:08.
- Same cycle clr+load+run_tgl while running at 00:00:07 → 00:00:00, running=0, hold=0, load_err=0.
